count_monitor: RTL and testbench

Free-running sequence checker that sits on the consumer side of the 8-bit up-counter's count bus.
- Samples count every clk and tracks that each value equals the previous value + 1, modulo 2^WIDTH.
- Reports lock, mismatch errors and wrap events through registered status outputs.
- Used by the ALU bench and in-system as a self-check on any counter-style source.

---
 rtl/count_monitor_pkg.sv | 18 +
 rtl/count_monitor_if.sv | 26 ++
 rtl/count_monitor_sat_counter.sv | 23 ++
 rtl/count_monitor.sv | 116 +++++++++++
 tb/tb_count_monitor.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/count_monitor_pkg.sv
// Shared types and sizing helpers for the count_monitor sequence checker.
package count_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  localparam int LOCK_CNT_DEF = 4;
  localparam int STREAK_W_DEF = $clog2(LOCK_CNT_DEF + 1);

  // Streak counter must hold the value LOCK_CNT itself.
  function automatic int streak_w(input int lock_cnt);
    return $clog2(lock_cnt + 1);
  endfunction

endpackage

// File: rtl/count_monitor_if.sv
// Count bus plus monitor status; master drives the bus, slave is the monitor.
interface count_monitor_if #(
  parameter int WIDTH  = 8,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
);
  logic              check_en;
  logic              clr;
  logic [WIDTH-1:0]  count;
  logic              locked;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_count;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic [WIDTH-1:0]  expected;

  modport master (
    output check_en, clr, count,
    input  locked, err_pulse, err_count, wrap_pulse, wrap_count, expected
  );

  modport slave (
    input  check_en, clr, count,
    output locked, err_pulse, err_count, wrap_pulse, wrap_count, expected
  );
endinterface

// File: rtl/count_monitor_sat_counter.sv
// Event counter with synchronous clear; optionally sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  input  logic         sat_en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !(sat_en && (&q))) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Checks that the observed count steps by +1 each clk; reports lock, errors, wraps.
//  state   | meaning
//  IDLE    | checking disabled, prev held
//  ACQUIRE | counting consecutive good increments toward lock
//  TRACK   | locked; mismatches raise err_pulse, max->0 raises wrap_pulse
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8,
  parameter int WRAP_W   = 8
) (
  input  logic           clk,
  input  logic           reset,
  count_monitor_if.slave mon
);

  localparam int              SW       = streak_w(LOCK_CNT);
  localparam logic [SW-1:0]   LOCK_TGT = SW'(LOCK_CNT);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] prev, prev_nx, prev_inc;
  logic [SW-1:0]    streak, streak_nx;
  logic             match, err_nx, wrap_nx;
  logic             locked_q, err_q, wrap_q;
  logic [WIDTH-1:0] expected_q;

  // Kept in WIDTH bits so the max->0 step counts as a match.
  assign prev_inc = prev + WIDTH'(1);
  assign match    = (mon.count == prev_inc);

  always_comb begin
    state_nx  = state;
    prev_nx   = prev;
    streak_nx = streak;
    err_nx    = 1'b0;
    wrap_nx   = 1'b0;
    if (!mon.check_en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          prev_nx   = mon.count;
          streak_nx = '0;
          state_nx  = ACQUIRE;
        end
        ACQUIRE: begin
          prev_nx = mon.count;
          if (match) begin
            streak_nx = streak + SW'(1);
            if (streak_nx == LOCK_TGT) state_nx = TRACK;
          end else begin
            streak_nx = '0;
          end
        end
        TRACK: begin
          prev_nx = mon.count;
          if (match) begin
            wrap_nx = (prev == MAX_VAL);
          end else begin
            err_nx    = 1'b1;
            streak_nx = '0;
            state_nx  = ACQUIRE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prev       <= '0;
      streak     <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      wrap_q     <= 1'b0;
      expected_q <= WIDTH'(1);
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      streak     <= streak_nx;
      locked_q   <= (state_nx == TRACK);
      err_q      <= err_nx;
      wrap_q     <= wrap_nx;
      expected_q <= prev_nx + WIDTH'(1);
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .inc    (err_nx),
    .clr    (mon.clr),
    .sat_en (1'b1),
    .q      (mon.err_count)
  );

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .inc    (wrap_nx),
    .clr    (mon.clr),
    .sat_en (1'b0),
    .q      (mon.wrap_count)
  );

  assign mon.locked     = locked_q;
  assign mon.err_pulse  = err_q;
  assign mon.wrap_pulse = wrap_q;
  assign mon.expected   = expected_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: a vector table plus hand-written corner sequences.
module tb_count_monitor;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  count_monitor_if #(.WIDTH(8), .ERR_W(8), .WRAP_W(8)) bus ();

  count_monitor #(.WIDTH(8), .LOCK_CNT(4), .ERR_W(8), .WRAP_W(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .mon   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [7:0] cnt;
    logic       lk;
    logic       ep;
    logic [7:0] ec;
    logic       wp;
    logic [7:0] wc;
    logic [7:0] ex;
  } vec_t;

  vec_t tbl[36];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic step(input logic e, input logic c, input logic [7:0] v);
    @(negedge clk);
    bus.check_en = e;
    bus.clr      = c;
    bus.count    = v;
    @(posedge clk);
    #1;
  endtask

  // Resync at F9, lock on FD, then step FE, FF, 00 with optional clr on the wrap edge.
  task automatic run_to_wrap(input string tag, input logic c, input logic f9_ep,
                             input logic [7:0] f9_ec, input logic [7:0] w_ec,
                             input logic [7:0] w_wc);
    step(1'b1, 1'b0, 8'hF9);
    chk({tag, " f9 err_pulse"}, 32'(bus.err_pulse), 32'(f9_ep));
    chk({tag, " f9 err_count"}, 32'(bus.err_count), 32'(f9_ec));
    chk({tag, " f9 locked"}, 32'(bus.locked), 0);
    for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 8'hF9 + 8'(k));
    chk({tag, " relock"}, 32'(bus.locked), 1);
    chk({tag, " expected"}, 32'(bus.expected), 32'h FE);
    step(1'b1, 1'b0, 8'hFE);
    step(1'b1, 1'b0, 8'hFF);
    chk({tag, " no early wrap"}, 32'(bus.wrap_pulse), 0);
    step(1'b1, c, 8'h00);
    chk({tag, " wrap_pulse"}, 32'(bus.wrap_pulse), 1);
    chk({tag, " wrap_count"}, 32'(bus.wrap_count), 32'(w_wc));
    chk({tag, " err_count"}, 32'(bus.err_count), 32'(w_ec));
    chk({tag, " locked"}, 32'(bus.locked), 1);
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] m;
    logic [7:0] ec_m;

    //         en clr cnt    lk ep ec     wp wc     ex
    tbl[0]  = '{1, 0, 8'h00, 0, 0, 8'd0, 0, 8'd0, 8'h01};
    tbl[1]  = '{1, 0, 8'h01, 0, 0, 8'd0, 0, 8'd0, 8'h02};
    tbl[2]  = '{1, 0, 8'h02, 0, 0, 8'd0, 0, 8'd0, 8'h03};
    tbl[3]  = '{1, 0, 8'h03, 0, 0, 8'd0, 0, 8'd0, 8'h04};
    tbl[4]  = '{1, 0, 8'h04, 1, 0, 8'd0, 0, 8'd0, 8'h05};
    tbl[5]  = '{1, 0, 8'h05, 1, 0, 8'd0, 0, 8'd0, 8'h06};
    tbl[6]  = '{0, 0, 8'h55, 0, 0, 8'd0, 0, 8'd0, 8'h06};
    tbl[7]  = '{1, 0, 8'hF9, 0, 0, 8'd0, 0, 8'd0, 8'hFA};
    tbl[8]  = '{1, 0, 8'hFA, 0, 0, 8'd0, 0, 8'd0, 8'hFB};
    tbl[9]  = '{1, 0, 8'hFB, 0, 0, 8'd0, 0, 8'd0, 8'hFC};
    tbl[10] = '{1, 0, 8'hFC, 0, 0, 8'd0, 0, 8'd0, 8'hFD};
    tbl[11] = '{1, 0, 8'hFD, 1, 0, 8'd0, 0, 8'd0, 8'hFE};
    tbl[12] = '{1, 0, 8'hFE, 1, 0, 8'd0, 0, 8'd0, 8'hFF};
    tbl[13] = '{1, 0, 8'hFF, 1, 0, 8'd0, 0, 8'd0, 8'h00};
    tbl[14] = '{1, 0, 8'h00, 1, 0, 8'd0, 1, 8'd1, 8'h01};
    tbl[15] = '{1, 0, 8'h01, 1, 0, 8'd0, 0, 8'd1, 8'h02};
    tbl[16] = '{1, 0, 8'h0B, 0, 1, 8'd1, 0, 8'd1, 8'h0C};
    tbl[17] = '{1, 0, 8'h0C, 0, 0, 8'd1, 0, 8'd1, 8'h0D};
    tbl[18] = '{1, 0, 8'h0D, 0, 0, 8'd1, 0, 8'd1, 8'h0E};
    tbl[19] = '{1, 0, 8'h0E, 0, 0, 8'd1, 0, 8'd1, 8'h0F};
    tbl[20] = '{1, 0, 8'h0F, 1, 0, 8'd1, 0, 8'd1, 8'h10};
    tbl[21] = '{1, 0, 8'h10, 1, 0, 8'd1, 0, 8'd1, 8'h11};
    tbl[22] = '{1, 0, 8'h11, 1, 0, 8'd1, 0, 8'd1, 8'h12};
    tbl[23] = '{1, 0, 8'h13, 0, 1, 8'd2, 0, 8'd1, 8'h14};
    tbl[24] = '{1, 0, 8'h14, 0, 0, 8'd2, 0, 8'd1, 8'h15};
    tbl[25] = '{1, 0, 8'h15, 0, 0, 8'd2, 0, 8'd1, 8'h16};
    tbl[26] = '{1, 0, 8'h16, 0, 0, 8'd2, 0, 8'd1, 8'h17};
    tbl[27] = '{1, 0, 8'h17, 1, 0, 8'd2, 0, 8'd1, 8'h18};
    tbl[28] = '{1, 0, 8'h18, 1, 0, 8'd2, 0, 8'd1, 8'h19};
    tbl[29] = '{1, 0, 8'h18, 0, 1, 8'd3, 0, 8'd1, 8'h19};
    tbl[30] = '{1, 0, 8'h19, 0, 0, 8'd3, 0, 8'd1, 8'h1A};
    tbl[31] = '{1, 0, 8'h19, 0, 0, 8'd3, 0, 8'd1, 8'h1A};
    tbl[32] = '{1, 0, 8'h1A, 0, 0, 8'd3, 0, 8'd1, 8'h1B};
    tbl[33] = '{1, 0, 8'h1B, 0, 0, 8'd3, 0, 8'd1, 8'h1C};
    tbl[34] = '{1, 0, 8'h1C, 0, 0, 8'd3, 0, 8'd1, 8'h1D};
    tbl[35] = '{1, 0, 8'h1D, 1, 0, 8'd3, 0, 8'd1, 8'h1E};

    rst_n        = 1'b0;
    bus.check_en = 1'b0;
    bus.clr      = 1'b0;
    bus.count    = 8'h00;
    #12;
    chk("reset locked", 32'(bus.locked), 0);
    chk("reset err_pulse", 32'(bus.err_pulse), 0);
    chk("reset err_count", 32'(bus.err_count), 0);
    chk("reset wrap_pulse", 32'(bus.wrap_pulse), 0);
    chk("reset wrap_count", 32'(bus.wrap_count), 0);
    chk("reset expected", 32'(bus.expected), 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 36; i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].cnt);
      chk($sformatf("v%0d locked", i), 32'(bus.locked), 32'(tbl[i].lk));
      chk($sformatf("v%0d err_pulse", i), 32'(bus.err_pulse), 32'(tbl[i].ep));
      chk($sformatf("v%0d err_count", i), 32'(bus.err_count), 32'(tbl[i].ec));
      chk($sformatf("v%0d wrap_pulse", i), 32'(bus.wrap_pulse), 32'(tbl[i].wp));
      chk($sformatf("v%0d wrap_count", i), 32'(bus.wrap_count), 32'(tbl[i].wc));
      chk($sformatf("v%0d expected", i), 32'(bus.expected), 32'(tbl[i].ex));
    end

    // Drive err_count up to saturation: mismatch while locked, then relock.
    p    = 8'h1D;
    ec_m = 8'd3;
    for (int it = 0; it < 252; it++) begin
      m = p + 8'd3;
      step(1'b1, 1'b0, m);
      ec_m = ec_m + 8'd1;
      chk("sat loop err_pulse", 32'(bus.err_pulse), 1);
      chk("sat loop err_count", 32'(bus.err_count), 32'(ec_m));
      for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, m + 8'(k));
      p = m + 8'd4;
    end
    chk("sat preload locked", 32'(bus.locked), 1);
    chk("sat preload err_count", 32'(bus.err_count), 32'h FF);
    chk("sat preload wrap_count", 32'(bus.wrap_count), 1);

    step(1'b1, 1'b0, p + 8'd3);
    chk("saturate err_pulse", 32'(bus.err_pulse), 1);
    chk("saturate err_count", 32'(bus.err_count), 32'h FF);
    for (int k = 4; k <= 7; k++) step(1'b1, 1'b0, p + 8'(k));
    chk("saturate relock", 32'(bus.locked), 1);

    step(1'b1, 1'b1, 8'h0D);
    chk("clr+err err_pulse", 32'(bus.err_pulse), 1);
    chk("clr+err err_count", 32'(bus.err_count), 0);
    chk("clr+err wrap_count", 32'(bus.wrap_count), 0);
    chk("clr+err locked", 32'(bus.locked), 0);

    run_to_wrap("wrapA", 1'b0, 1'b0, 8'd0, 8'd0, 8'd1);
    run_to_wrap("wrapclr", 1'b1, 1'b1, 8'd1, 8'd0, 8'd0);
    step(1'b1, 1'b0, 8'h01);
    chk("wrap pulse width", 32'(bus.wrap_pulse), 0);
    chk("clr keeps lock", 32'(bus.locked), 1);
    run_to_wrap("wrapB", 1'b0, 1'b1, 8'd1, 8'd1, 8'd1);
    step(1'b1, 1'b0, 8'h01);

    // Reset between edges while locked with nonzero counters.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async locked", 32'(bus.locked), 0);
    chk("async err_count", 32'(bus.err_count), 0);
    chk("async wrap_count", 32'(bus.wrap_count), 0);
    chk("async expected", 32'(bus.expected), 1);
    chk("async err_pulse", 32'(bus.err_pulse), 0);
    bus.check_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 1'b0, 8'h05);
    chk("post-reset acquire", 32'(bus.locked), 0);
    chk("post-reset expected", 32'(bus.expected), 32'h06);
    for (int k = 6; k <= 9; k++) step(1'b1, 1'b0, 8'(k));
    chk("post-reset lock", 32'(bus.locked), 1);
    step(1'b0, 1'b0, 8'h33);
    chk("disable locked", 32'(bus.locked), 0);
    chk("disable err_pulse", 32'(bus.err_pulse), 0);
    chk("disable wrap_pulse", 32'(bus.wrap_pulse), 0);
    chk("disable expected", 32'(bus.expected), 32'h0A);
    step(1'b0, 1'b0, 8'h44);
    chk("idle hold expected", 32'(bus.expected), 32'h0A);
    chk("idle hold err_count", 32'(bus.err_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
